// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with a valid/ready output register.
// Optional parity stage is built when the UART_RX_PARITY_EN macro is defined.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 uart_rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CELL_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1))
    begin : g_param_check
        $error("uart_rx_param: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DELIVER,
        S_BREAK
    } state_e;

    state_e               state_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_acc_q;
    logic                 parity_acc_q;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_q;
    logic                 parity_q;
    logic                 overrun_q;

    logic [DATA_BITS-1:0] shift_d;
    logic                 parity_err_d;
    logic                 cell_mid;
    logic                 cell_last;
    logic                 load_ok;

    // Line bits arrive LSB first, so each new sample enters at the top.
    always_comb begin
        shift_d      = {rx_s_q, shift_q[DATA_BITS-1:1]};
        parity_err_d = ((^shift_q) ^ rx_s_q) != 1'(PARITY_ODD);
        cell_mid     = (cnt_q == CELL_MID);
        cell_last    = (cnt_q == CELL_LAST);
        load_ok      = !valid_q || rx_ready_i;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
            frame_acc_q  <= 1'b0;
            parity_acc_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_q      <= 1'b0;
            parity_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_s_q    <= rx_meta_q;
            overrun_q <= 1'b0;

            // A completed handshake frees the register unless DELIVER refills it below.
            if (valid_q && rx_ready_i) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                    end
                end

                S_START: begin
                    if (cell_mid) begin
                        cnt_q        <= '0;
                        bit_cnt_q    <= '0;
                        stop_cnt_q   <= 1'b0;
                        frame_acc_q  <= 1'b0;
                        parity_acc_q <= 1'b0;
                        state_q      <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cell_last) begin
                        cnt_q     <= '0;
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cell_last) begin
                        cnt_q        <= '0;
                        parity_acc_q <= parity_err_d;
                        state_q      <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (cell_last) begin
                        cnt_q      <= '0;
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                        if (!rx_s_q) begin
                            frame_acc_q <= 1'b1;
                        end
                        if (stop_cnt_q == STOP_LAST) begin
                            state_q <= S_DELIVER;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_DELIVER: begin
                    cnt_q <= '0;
                    if (load_ok) begin
                        data_q   <= shift_q;
                        frame_q  <= frame_acc_q;
                        parity_q <= parity_acc_q;
                        valid_q  <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                    // A low line after a bad stop bit is a break; wait for idle before rearming.
                    state_q <= (frame_acc_q && !rx_s_q) ? S_BREAK : S_IDLE;
                end

                S_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = frame_q;
    assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
